// File: rtl/or3_bist_pkg.sv
// Shared definitions for the 3-input OR gate self-test sequencer.
//   - bist_state_e : sequencer FSM states
//   - PAT_W/NUM_PAT: pattern counter width and number of input patterns
//   - or3_expected : golden response of a healthy OR3 gate
package or3_bist_pkg;

  localparam int unsigned PAT_W   = 3;
  localparam int unsigned NUM_PAT = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCheck,
    StDone
  } bist_state_e;

  function automatic logic or3_expected(input logic [PAT_W-1:0] pattern);
    return |pattern;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-stage flip-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset, chain clears to 0
//   d_i    - asynchronous input bit
//   q_o    - synchronized output (last stage)
module bit_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/or3_selftest_ctrl.sv
// Built-in self-test sequencer for a 3-input OR gate. Steps through all eight
// input patterns, holds each for SETTLE_CYCLES, samples the synchronized gate
// output and records mismatches.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   start      - begin a run (ignored while busy or with abort)
//   abort      - stop a run in progress, partial results are kept
//   abc_o      - pattern to the gate {a, b, c}
//   y_i        - gate output, asynchronous to clk
//   busy, done, pass, err_count, fail_vec - registered status/results
module or3_selftest_ctrl
  import or3_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [PAT_W-1:0]   abc_o,
  input  logic               y_i,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [3:0]         err_count,
  output logic [NUM_PAT-1:0] fail_vec
);

  localparam logic [3:0]       WaitReload = 4'(SETTLE_CYCLES - 1);
  localparam logic [PAT_W-1:0] LastPat    = PAT_W'(NUM_PAT - 1);

  logic y_sync;

  bit_sync #(
    .Stages(SYNC_STAGES)
  ) u_y_sync (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   (y_i),
    .q_o   (y_sync)
  );

  bist_state_e        state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [3:0]         wait_q, wait_d;
  logic [PAT_W-1:0]   abc_q, abc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [3:0]         err_q, err_d;
  logic [NUM_PAT-1:0] fail_q, fail_d;
  logic               mismatch;

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    wait_d   = wait_q;
    abc_d    = abc_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;
    mismatch = y_sync != or3_expected(pat_q);

    unique case (state_q)
      StIdle, StDone: begin
        if (start && !abort) begin
          state_d = StSettle;
          pat_d   = '0;
          abc_d   = '0;
          wait_d  = WaitReload;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fail_d  = '0;
        end
      end

      StSettle: begin
        if (abort) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          abc_d   = '0;
        end else if (wait_q == 4'd0) begin
          state_d = StCheck;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      StCheck: begin
        if (abort) begin
          // A mismatch seen in this cycle is dropped on purpose.
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          abc_d   = '0;
        end else begin
          if (mismatch) begin
            err_d         = err_q + 4'd1;
            fail_d[pat_q] = 1'b1;
          end
          if (pat_q == LastPat) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 4'd0);
            abc_d   = '0;
          end else begin
            state_d = StSettle;
            pat_d   = pat_q + 3'd1;
            abc_d   = pat_q + 3'd1;
            wait_d  = WaitReload;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pat_q   <= '0;
      wait_q  <= '0;
      abc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      wait_q  <= wait_d;
      abc_q   <= abc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign abc_o     = abc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule
